// File: rtl/nib_pkg.sv
// Shared types for the nibble packer: nibble/byte payload types and FSM states.
package nib_pkg;

  typedef logic [3:0] nib_t;
  typedef logic [7:0] byte_t;

  // 2'd0 is deliberately unused so a stuck-at-zero state register is visibly illegal
  typedef enum logic [1:0] {
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_FULL = 2'd3
  } pack_state_t;

endpackage

// File: rtl/nibble_pack_fsm.sv
// Nibble-to-byte packer: pairs nibbles (low first) into bytes, frames them into
// NUM_BYTES-byte packets and optionally reports a running additive checksum.
module nibble_pack_fsm
  import nib_pkg::*;
#(
  parameter int NUM_BYTES = 4,
  parameter bit CHK_EN    = 1'b1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_valid,
  output logic  in_ready,
  input  nib_t  in_data,
  output logic  out_valid,
  input  logic  out_ready,
  output byte_t out_data,
  output logic  out_last,
  output byte_t out_chk
);

  localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  typedef logic [CNT_W-1:0] cnt_t;
  // Narrow sum_t only sizes the held low nibble; the checksum block shadows it
  typedef logic [3:0] sum_t;

  pack_state_t state, state_nxt;
  sum_t        lo_q;
  cnt_t        cnt_q;
  logic        take_lo, take_hi, xfer;
  byte_t       byte_nxt;
  logic        last_nxt;

  assign byte_nxt = {in_data, lo_q};
  assign last_nxt = (cnt_q == cnt_t'(NUM_BYTES - 1));

  // State register; an illegal encoding falls back to ST_LO through state_nxt
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_LO;
    else        state <= state_nxt;
  end

  // Next-state and handshake decode; in_ready is forced low while in reset
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    take_lo   = 1'b0;
    take_hi   = 1'b0;
    xfer      = 1'b0;
    case (state)
      ST_LO: begin
        in_ready = rst_n;
        if (in_valid) begin
          take_lo   = 1'b1;
          state_nxt = ST_HI;
        end
      end
      ST_HI: begin
        in_ready = rst_n;
        if (in_valid) begin
          take_hi   = 1'b1;
          state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          xfer      = 1'b1;
          state_nxt = ST_LO;
        end
      end
      default: state_nxt = ST_LO;
    endcase
  end

  // Datapath: nibble latch, output byte register, and packet byte counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lo_q      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (take_lo) lo_q <= in_data;
      if (take_hi) begin
        out_data  <= byte_nxt;
        out_last  <= last_nxt;
        out_valid <= 1'b1;
      end
      if (xfer) begin
        out_valid <= 1'b0;
        cnt_q     <= out_last ? '0 : cnt_q + 1'b1;
      end
    end
  end

  if (CHK_EN) begin : g_chk
    typedef logic [7:0] sum_t;
    sum_t acc;
    sum_t chk_q;

    // Running sum of already-transferred bytes; the presented checksum folds in the current byte
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        acc   <= '0;
        chk_q <= '0;
      end else begin
        if (take_hi) chk_q <= acc + byte_nxt;
        if (xfer)    acc   <= out_last ? '0 : acc + out_data;
      end
    end

    assign out_chk = chk_q;
  end else begin : g_no_chk
    assign out_chk = 8'h00;
  end

endmodule

// File: tb/tb_nibble_pack_fsm.sv
// Directed bench: three packers (4 bytes w/ checksum, 4 bytes w/o, 2 bytes w/)
// driven by the same nibble stream, checked against hand-computed bytes.
module tb_nibble_pack_fsm;
  import nib_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n, in_valid, out_ready;
  nib_t  in_data;
  logic  rdy0, rdy1, rdy2, v0, v1, v2, l0, l1, l2;
  byte_t d0, d1, d2, c0, c1, c2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nibble_pack_fsm #(.NUM_BYTES(4), .CHK_EN(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .out_valid(v0), .out_ready(out_ready), .out_data(d0), .out_last(l0), .out_chk(c0));
  nibble_pack_fsm #(.NUM_BYTES(4), .CHK_EN(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .out_valid(v1), .out_ready(out_ready), .out_data(d1), .out_last(l1), .out_chk(c1));
  nibble_pack_fsm #(.NUM_BYTES(2), .CHK_EN(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
    .out_valid(v2), .out_ready(out_ready), .out_data(d2), .out_last(l2), .out_chk(c2));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one byte through all three units; xfer=1 completes the handshake afterwards
  task automatic send(input string tag, input nib_t lo, input nib_t hi, input byte_t eb,
                      input logic el0, input byte_t ec0, input logic el2, input byte_t ec2,
                      input bit do_xfer);
    in_valid = 1'b1;
    in_data  = lo;
    tick();
    chk({tag, ".v_after_lo"}, {7'd0, v0}, 8'd0);
    chk({tag, ".rdy_after_lo"}, {7'd0, rdy0}, 8'd1);
    in_data = hi;
    tick();
    in_valid = 1'b0;
    chk({tag, ".v0"}, {7'd0, v0}, 8'd1);
    chk({tag, ".rdy0_full"}, {7'd0, rdy0}, 8'd0);
    chk({tag, ".d0"}, d0, eb);
    chk({tag, ".l0"}, {7'd0, l0}, {7'd0, el0});
    chk({tag, ".c0"}, c0, ec0);
    chk({tag, ".d1"}, d1, eb);
    chk({tag, ".l1"}, {7'd0, l1}, {7'd0, el0});
    chk({tag, ".c1"}, c1, 8'h00);
    chk({tag, ".d2"}, d2, eb);
    chk({tag, ".l2"}, {7'd0, l2}, {7'd0, el2});
    chk({tag, ".c2"}, c2, ec2);
    if (do_xfer) begin
      tick();
      chk({tag, ".v0_after_xfer"}, {7'd0, v0}, 8'd0);
      chk({tag, ".rdy0_after_xfer"}, {7'd0, rdy0}, 8'd1);
    end
  endtask

  // out_data must hold while a byte is stalled by out_ready
  logic  pv = 1'b0, pr = 1'b0, prst = 1'b0;
  byte_t pd = '0;
  always @(negedge clk) begin
    if (pv && !pr && prst) chk("stable_out_data", d0, pd);
    pv   = v0;
    pr   = out_ready;
    prst = rst_n;
    pd   = d0;
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst.v", {7'd0, v0}, 8'd0);
    chk("rst.d", d0, 8'h00);
    chk("rst.l", {7'd0, l0}, 8'd0);
    chk("rst.c", c0, 8'h00);
    chk("rst.rdy", {7'd0, rdy0}, 8'd0);
    chk("rst.state", {6'd0, u0.state}, {6'd0, ST_LO});
    rst_n = 1'b1;
    #1;
    chk("post_rst.rdy", {7'd0, rdy0}, 8'd1);

    // packet A: A5 5A 42 01 -> checksum 42 on last byte
    send("A0", 4'h5, 4'hA, 8'hA5, 1'b0, 8'hA5, 1'b0, 8'hA5, 1'b1);
    send("A1", 4'hA, 4'h5, 8'h5A, 1'b0, 8'hFF, 1'b1, 8'hFF, 1'b1);
    send("A2", 4'h2, 4'h4, 8'h42, 1'b0, 8'h41, 1'b0, 8'h42, 1'b1);
    send("A3", 4'h1, 4'h0, 8'h01, 1'b1, 8'h42, 1'b1, 8'h43, 1'b1);

    // packet B: first byte 3C stalled for 3 cycles with in_valid pulsing garbage
    out_ready = 1'b0;
    send("B0", 4'hC, 4'h3, 8'h3C, 1'b0, 8'h3C, 1'b0, 8'h3C, 1'b0);
    in_valid = 1'b1;
    in_data  = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp.v", {7'd0, v0}, 8'd1);
      chk("bp.d", d0, 8'h3C);
      chk("bp.rdy", {7'd0, rdy0}, 8'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_rel.v", {7'd0, v0}, 8'd0);
    chk("bp_rel.rdy", {7'd0, rdy0}, 8'd1);
    send("B1", 4'h0, 4'h1, 8'h10, 1'b0, 8'h4C, 1'b1, 8'h4C, 1'b1);
    send("B2", 4'h0, 4'h2, 8'h20, 1'b0, 8'h6C, 1'b0, 8'h20, 1'b1);

    // hold a lo nibble, then a 1-cycle reset mid-packet
    in_valid = 1'b1;
    in_data  = 4'h7;
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("mrst.rdy_in_rst", {7'd0, rdy0}, 8'd0);
    tick();
    chk("mrst.v", {7'd0, v0}, 8'd0);
    chk("mrst.d", d0, 8'h00);
    chk("mrst.l", {7'd0, l0}, 8'd0);
    chk("mrst.c", c0, 8'h00);
    chk("mrst.state", {6'd0, u0.state}, {6'd0, ST_LO});
    rst_n = 1'b1;

    // fresh packet after reset: 11 22 33 44 -> checksum AA
    send("C0", 4'h1, 4'h1, 8'h11, 1'b0, 8'h11, 1'b0, 8'h11, 1'b1);
    send("C1", 4'h2, 4'h2, 8'h22, 1'b0, 8'h33, 1'b1, 8'h33, 1'b1);
    send("C2", 4'h3, 4'h3, 8'h33, 1'b0, 8'h66, 1'b0, 8'h33, 1'b1);
    send("C3", 4'h4, 4'h4, 8'h44, 1'b1, 8'hAA, 1'b1, 8'h77, 1'b1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
